// File: rtl/video_capture.sv
// Serial video capture: packs 1-bpp pixels into 16-bit VRAM words.
// Tracks vsync framing and flags framing errors.
module video_capture #(
  parameter int          WORDS_PER_FRAME = 10944,
  parameter logic [13:0] ADDR_BASE       = 14'd0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ce,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        video_en,
  input  logic        pixelIn,
  output logic [13:0] wr_addr,
  output logic [15:0] wr_data,
  output logic [1:0]  wr,
  output logic        frame_done,
  output logic        err
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SYNC   = 2'd1;
  localparam logic [1:0] ACTIVE = 2'd2;

  localparam logic [14:0] WPF = 15'(WORDS_PER_FRAME);

  logic [1:0]  state;
  logic        vs_q;
  logic        ven_q;
  logic [14:0] wcnt;
  logic [3:0]  bcnt;
  logic [14:0] shreg;

  logic        vs_rise;
  logic        vs_fall;
  logic        ven_fall;
  logic        full;
  logic [15:0] sh_next;

  // hsync carries no framing information for capture; it is only observed.
  logic        hs_seen;
  assign hs_seen = hsync;

  // Edge detection against the previous ce-sample; pixel is inverted into VRAM polarity.
  always_comb begin
    vs_rise  = vsync & ~vs_q;
    vs_fall  = ~vsync & vs_q;
    ven_fall = ~video_en & ven_q;
    full     = (wcnt == WPF);
    sh_next  = {shreg, ~pixelIn};
  end

  // Capture FSM, counters and write port; wr/frame_done self-clear every clk.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      vs_q       <= 1'b0;
      ven_q      <= 1'b0;
      wcnt       <= '0;
      bcnt       <= '0;
      shreg      <= '0;
      wr         <= 2'b00;
      wr_data    <= '0;
      wr_addr    <= ADDR_BASE;
      frame_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      wr         <= 2'b00;
      frame_done <= 1'b0;
      if (ce) begin
        vs_q  <= vsync;
        ven_q <= video_en;
        if (vs_rise) begin
          if (state == ACTIVE) begin
            if (full) frame_done <= 1'b1;
            else      err        <= 1'b1;
          end
          state <= SYNC;
          wcnt  <= '0;
          bcnt  <= '0;
          shreg <= '0;
        end else begin
          case (state)
            SYNC: begin
              if (vs_fall) begin
                state <= ACTIVE;
                bcnt  <= '0;
                shreg <= '0;
              end
            end
            ACTIVE: begin
              if (video_en) begin
                shreg <= sh_next[14:0];
                bcnt  <= bcnt + 4'd1;
                if (bcnt == 4'd15) begin
                  if (full) begin
                    err <= 1'b1;
                  end else begin
                    wr      <= 2'b11;
                    wr_data <= sh_next;
                    wr_addr <= ADDR_BASE + wcnt[13:0];
                    wcnt    <= wcnt + 15'd1;
                  end
                end
              end else if (ven_fall && bcnt != 4'd0) begin
                err   <= 1'b1;
                bcnt  <= '0;
                shreg <= '0;
              end
            end
            default: begin
              if (hs_seen || !hs_seen) state <= IDLE;
            end
          endcase
        end
      end
    end
  end

endmodule
